sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, the next-generation replacement for the fixed-size synchronous fifo used across the design. Adds width/depth parameters, a first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty flags, an occupancy count and overflow/underflow error pulses. Sits between a producer and a consumer in the same clock domain and keeps the same data_in/wr_en/rd_en/data_out/full/empty handshake.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 45 ++++
 rtl/sync_fifo_param.sv | 110 +++++++++++
 tb/tb_sync_fifo_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  localparam int unsigned DefaultAeThresh = 2;
  localparam int unsigned DefaultAfMargin = 2;

  // Never returns 0, so address buses stay at least one bit wide.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, read port combinational (FWFT) or registered (STD).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 16,
  parameter fifo_mode_e  Mode      = FIFO_STD,
  parameter int unsigned AddrW     = clog2_safe(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [AddrW-1:0]     waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrW-1:0]     raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (Mode == FIFO_FWFT) begin : g_comb_rd
    assign rdata_o = mem_q[raddr_i];
  end else begin : g_reg_rd
    logic [DataWidth-1:0] rdata_q;

    // Old contents are returned when a read and write hit the same slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata_q <= '0;
      end else if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end

    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with width/depth parameters, optional FWFT, threshold flags and error pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = DEPTH - DefaultAfMargin,
  parameter int unsigned AE_THRESH  = DefaultAeThresh,
  parameter int unsigned FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [clog2_safe(DEPTH):0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW   = clog2_safe(DEPTH);
  localparam int unsigned PtrW = AW + 1;
  localparam fifo_mode_e  Mode = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_THRESH out of range");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_THRESH out of range");
  end

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       occ;
  logic                  wr_acc, rd_acc;
  logic                  overflow_q, underflow_q;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Extra wrap bit makes the modulo difference span 0..DEPTH.
  assign occ          = wr_ptr_q - rd_ptr_q;
  assign count        = occ;
  assign full         = (occ == PtrW'(DEPTH));
  assign empty        = (occ == '0);
  assign almost_full  = (occ >= PtrW'(AF_THRESH));
  assign almost_empty = (occ <= PtrW'(AE_THRESH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_acc   = rd_en && !empty;
    wr_acc   = wr_en && (!full || rd_acc);
    wr_ptr_d = wr_ptr_q + PtrW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PtrW'(rd_acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= wr_en && !wr_acc;
      underflow_q <= rd_en && !rd_acc;
    end
  end

  fifo_mem #(
    .DataWidth(DATA_WIDTH),
    .Depth    (DEPTH),
    .Mode     (Mode),
    .AddrW    (AW)
  ) u_mem (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q[AW-1:0]),
    .wdata_i(data_in),
    .re_i   (rd_acc),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(mem_rdata)
  );

  if (Mode == FIFO_FWFT) begin : g_fwft_out
    logic [DATA_WIDTH-1:0] hold_q;

    // Remembers the last head shown so data_out is stable once the FIFO drains.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_q <= '0;
      end else if (!empty) begin
        hold_q <= mem_rdata;
      end
    end

    assign data_out = empty ? hold_q : mem_rdata;
  end else begin : g_std_out
    assign data_out = mem_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: standard-mode and FWFT instances share clock and reset.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] s_din = '0, s_dout;
  logic       s_wr = 1'b0, s_rd = 1'b0;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [4:0] s_count;

  logic [7:0] f_din = '0, f_dout;
  logic       f_wr = 1'b0, f_rd = 1'b0;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_fifo_param u_std (
    .clk         (clk),
    .rst         (rst),
    .data_in     (s_din),
    .wr_en       (s_wr),
    .rd_en       (s_rd),
    .data_out    (s_dout),
    .full        (s_full),
    .empty       (s_empty),
    .almost_full (s_af),
    .almost_empty(s_ae),
    .count       (s_count),
    .overflow    (s_ovf),
    .underflow   (s_unf)
  );

  sync_fifo_param #(.FWFT(1)) u_fwft (
    .clk         (clk),
    .rst         (rst),
    .data_in     (f_din),
    .wr_en       (f_wr),
    .rd_en       (f_rd),
    .data_out    (f_dout),
    .full        (f_full),
    .empty       (f_empty),
    .almost_full (f_af),
    .almost_empty(f_ae),
    .count       (f_count),
    .overflow    (f_ovf),
    .underflow   (f_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic s_step(input logic w, input logic r, input logic [7:0] d);
    s_wr  = w;
    s_rd  = r;
    s_din = d;
    @(posedge clk);
    #1;
    s_wr = 1'b0;
    s_rd = 1'b0;
  endtask

  task automatic f_step(input logic w, input logic r, input logic [7:0] d);
    f_wr  = w;
    f_rd  = r;
    f_din = d;
    @(posedge clk);
    #1;
    f_wr = 1'b0;
    f_rd = 1'b0;
  endtask

  function automatic logic [7:0] wv(input int k);
    return 8'(k * 37 + 5);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_rd;

    #3 rst = 1'b0;
    #2;
    check("rst_empty", 32'(s_empty), 32'd1);
    check("rst_ae", 32'(s_ae), 32'd1);
    check("rst_full", 32'(s_full), 32'd0);
    check("rst_af", 32'(s_af), 32'd0);
    check("rst_count", 32'(s_count), 32'd0);
    check("rst_dout", 32'(s_dout), 32'd0);
    check("rst_ovf", 32'(s_ovf), 32'd0);
    check("rst_unf", 32'(s_unf), 32'd0);
    check("rst_fwft_dout", 32'(f_dout), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_empty", 32'(s_empty), 32'd1);
    check("idle_count", 32'(s_count), 32'd0);

    // Mid-stream reset after five writes.
    for (int i = 1; i <= 5; i++) s_step(1'b1, 1'b0, 8'(i));
    check("pre_rst_count", 32'(s_count), 32'd5);
    check("pre_rst_ae", 32'(s_ae), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_count", 32'(s_count), 32'd0);
    check("mid_rst_empty", 32'(s_empty), 32'd1);
    check("mid_rst_ae", 32'(s_ae), 32'd1);
    check("mid_rst_full", 32'(s_full), 32'd0);
    check("mid_rst_af", 32'(s_af), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, checking threshold crossings on the way.
    for (int i = 0; i < 16; i++) begin
      s_step(1'b1, 1'b0, 8'(i));
      if (i == 1) check("fill2_ae", 32'(s_ae), 32'd1);
      if (i == 2) check("fill3_ae", 32'(s_ae), 32'd0);
      if (i == 12) check("fill13_af", 32'(s_af), 32'd0);
      if (i == 13) check("fill14_af", 32'(s_af), 32'd1);
      if (i == 14) check("fill15_full", 32'(s_full), 32'd0);
    end
    check("full_flag", 32'(s_full), 32'd1);
    check("full_count", 32'(s_count), 32'd16);

    s_step(1'b1, 1'b0, 8'hAA);
    check("ovf_pulse", 32'(s_ovf), 32'd1);
    check("ovf_count", 32'(s_count), 32'd16);
    s_step(1'b0, 1'b0, 8'h00);
    check("ovf_clear", 32'(s_ovf), 32'd0);

    // Write alongside a read while full.
    s_step(1'b1, 1'b1, 8'h55);
    check("fullrw_count", 32'(s_count), 32'd16);
    check("fullrw_full", 32'(s_full), 32'd1);
    check("fullrw_dout", 32'(s_dout), 32'h00);
    check("fullrw_ovf", 32'(s_ovf), 32'd0);

    for (int i = 0; i < 16; i++) begin
      exp_rd = (i < 15) ? 8'(i + 1) : 8'h55;
      s_step(1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d_dout", i), 32'(s_dout), 32'(exp_rd));
      check($sformatf("drain%0d_count", i), 32'(s_count), 32'(15 - i));
      if (i == 1) check("drain_af14", 32'(s_af), 32'd1);
      if (i == 2) check("drain_af13", 32'(s_af), 32'd0);
      if (i == 12) check("drain_ae3", 32'(s_ae), 32'd0);
      if (i == 13) check("drain_ae2", 32'(s_ae), 32'd1);
    end
    check("drained_empty", 32'(s_empty), 32'd1);
    s_step(1'b0, 1'b0, 8'h00);
    check("hold_dout", 32'(s_dout), 32'h55);

    // Read on empty.
    s_step(1'b0, 1'b1, 8'h00);
    check("unf_pulse", 32'(s_unf), 32'd1);
    check("unf_count", 32'(s_count), 32'd0);
    check("unf_dout", 32'(s_dout), 32'h55);
    s_step(1'b0, 1'b0, 8'h00);
    check("unf_clear", 32'(s_unf), 32'd0);

    // Simultaneous write and read while empty: no pass-through.
    s_step(1'b1, 1'b1, 8'h77);
    check("emptyrw_count", 32'(s_count), 32'd1);
    check("emptyrw_unf", 32'(s_unf), 32'd1);
    check("emptyrw_dout", 32'(s_dout), 32'h55);
    check("emptyrw_empty", 32'(s_empty), 32'd0);
    s_step(1'b0, 1'b1, 8'h00);
    check("emptyrw_rd_dout", 32'(s_dout), 32'h77);
    check("emptyrw_rd_count", 32'(s_count), 32'd0);
    check("emptyrw_rd_unf", 32'(s_unf), 32'd0);

    // FWFT instance.
    f_step(1'b1, 1'b0, 8'h3C);
    check("fwft_first_dout", 32'(f_dout), 32'h3C);
    check("fwft_first_empty", 32'(f_empty), 32'd0);
    f_step(1'b0, 1'b0, 8'h00);
    check("fwft_idle_dout", 32'(f_dout), 32'h3C);
    f_step(1'b1, 1'b0, 8'h3D);
    check("fwft_wr2_dout", 32'(f_dout), 32'h3C);
    check("fwft_wr2_count", 32'(f_count), 32'd2);
    f_step(1'b0, 1'b1, 8'h00);
    check("fwft_rd_dout", 32'(f_dout), 32'h3D);
    check("fwft_rd_count", 32'(f_count), 32'd1);
    f_step(1'b0, 1'b1, 8'h00);
    check("fwft_drain_empty", 32'(f_empty), 32'd1);
    check("fwft_drain_dout", 32'(f_dout), 32'h3D);
    f_step(1'b0, 1'b1, 8'h00);
    check("fwft_unf", 32'(f_unf), 32'd1);
    check("fwft_unf_dout", 32'(f_dout), 32'h3D);

    // Wrap: keep two entries in flight across several pointer wraps.
    f_step(1'b1, 1'b0, wv(0));
    f_step(1'b1, 1'b0, wv(1));
    check("fwft_wrap_head", 32'(f_dout), 32'(wv(0)));
    for (int i = 0; i < 40; i++) begin
      f_step(1'b1, 1'b1, wv(i + 2));
      check($sformatf("wrap%0d_dout", i), 32'(f_dout), 32'(wv(i + 1)));
      check($sformatf("wrap%0d_count", i), 32'(f_count), 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
